// File: rtl/crc16_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : crc16_tx_framer                                                 |
// | Brief    : Forwards payload bytes and appends a byte-parallel CRC-16.      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module crc16_tx_framer #(
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] crc_out,
  output logic        crc_done
);

  localparam logic [1:0] ST_PAYLOAD = 2'd0;
  localparam logic [1:0] ST_CRC_HI  = 2'd1;
  localparam logic [1:0] ST_CRC_LO  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic        crc_done_q, crc_done_d;
  logic        out_free;
  logic        s_ready_w;
  logic [15:0] crc_fin;

  // MSB-first shift of one byte through the CRC register, unrolled in one cycle.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return r;
  endfunction

  always_comb begin
    out_free   = !m_valid_q || m_ready;
    crc_fin    = crc_q ^ XOROUT;
    state_d    = state_q;
    crc_d      = crc_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;
    crc_out_d  = crc_out_q;
    crc_done_d = 1'b0;
    s_ready_w  = 1'b0;

    // Beat consumed and nothing replaces it: drop valid; any load below overrides.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_PAYLOAD: begin
        s_ready_w = out_free;
        if (s_valid && out_free) begin
          m_data_d  = s_data;
          m_last_d  = 1'b0;
          m_valid_d = 1'b1;
          crc_d     = crc_byte(crc_q, s_data);
          if (s_last) begin
            state_d = ST_CRC_HI;
          end
        end
      end
      ST_CRC_HI: begin
        if (out_free) begin
          m_data_d  = crc_fin[15:8];
          m_last_d  = 1'b0;
          m_valid_d = 1'b1;
          state_d   = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (out_free) begin
          m_data_d   = crc_fin[7:0];
          m_last_d   = 1'b1;
          m_valid_d  = 1'b1;
          crc_out_d  = crc_fin;
          crc_done_d = 1'b1;
          crc_d      = INIT;
          state_d    = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_PAYLOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PAYLOAD;
      crc_q      <= INIT;
      m_data_q   <= 8'h00;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      crc_out_q  <= 16'h0000;
      crc_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      crc_out_q  <= crc_out_d;
      crc_done_q <= crc_done_d;
    end
  end

  // Held low during reset even though the output register is empty.
  assign s_ready  = s_ready_w & rst_n;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign crc_out  = crc_out_q;
  assign crc_done = crc_done_q;

endmodule
`default_nettype wire

// File: tb/tb_crc16_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_crc16_tx_framer                                              |
// | Brief    : Randomized self-checking bench with a queue-based frame model.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_crc16_tx_framer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready, s_ready_z;
  logic [7:0]  m_data, m_data_z;
  logic        m_valid, m_valid_z;
  logic        m_last, m_last_z;
  logic        m_ready;
  logic [15:0] crc_out, crc_out_z;
  logic        crc_done, crc_done_z;

  crc16_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .crc_out(crc_out), .crc_done(crc_done)
  );

  crc16_tx_framer #(.INIT(16'h0000)) dut_z (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_z), .m_data(m_data_z), .m_valid(m_valid_z), .m_last(m_last_z),
    .m_ready(m_ready), .crc_out(crc_out_z), .crc_done(crc_done_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b1;
  bit          rdy_rand = 1'b0;
  logic [8:0]  exp_q[$];
  logic [15:0] exp_crc_q[$];
  logic [15:0] exp_crc_z_q[$];
  int          beat_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Polynomial long division of the message bit stream, most significant bit first.
  function automatic logic [15:0] ref_crc(input logic [7:0] msg[$], input logic [15:0] init);
    logic [15:0] rem;
    logic        top;
    rem = init;
    foreach (msg[k]) begin
      for (int b = 7; b >= 0; b--) begin
        top = rem[15] ^ msg[k][b];
        rem = (rem << 1) ^ (top ? 16'h1021 : 16'h0000);
      end
    end
    return rem;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor: sampled at the falling edge, when every input has settled.
  initial begin
    bit         prev_stall;
    logic [8:0] prev_beat;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, m_valid}, 32'd1);
          chk("hold_data", {23'd0, m_last, m_data}, {23'd0, prev_beat});
        end
        prev_stall = m_valid && !m_ready;
        prev_beat  = {m_last, m_data};
        if (mon_en && m_valid && m_ready) begin
          beat_cyc.push_back(cyc);
          if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 32'd1);
          else chk("beat", {23'd0, m_last, m_data}, {23'd0, exp_q.pop_front()});
        end
        if (crc_done) begin
          done_cnt++;
          chk("done_on_last", {30'd0, m_valid, m_last}, 32'd3);
          if (exp_crc_q.size() == 0) chk("extra_done", exp_crc_q.size(), 32'd1);
          else chk("crc_out", {16'd0, crc_out}, {16'd0, exp_crc_q.pop_front()});
        end
        if (crc_done_z) begin
          if (exp_crc_z_q.size() == 0) chk("extra_done_z", exp_crc_z_q.size(), 32'd1);
          else chk("crc_out_z", {16'd0, crc_out_z}, {16'd0, exp_crc_z_q.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps, output int waits);
    bit got;
    waits = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    got     = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = s_ready;
      if (!got) waits++;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      $display("FAIL handshake_timeout: got no s_ready expected s_ready");
      $fatal(1, "stalled input");
    end
  endtask

  task automatic send_frame(input logic [7:0] msg[$], input bit gaps, output int first_waits);
    logic [15:0] c;
    int          w;
    foreach (msg[k]) exp_q.push_back({1'b0, msg[k]});
    c = ref_crc(msg, 16'hFFFF);
    exp_q.push_back({1'b0, c[15:8]});
    exp_q.push_back({1'b1, c[7:0]});
    exp_crc_q.push_back(c);
    exp_crc_z_q.push_back(ref_crc(msg, 16'h0000));
    first_waits = 0;
    foreach (msg[k]) begin
      send_byte(msg[k], k == msg.size() - 1, gaps, w);
      if (k == 0) first_waits = w;
    end
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 300 && (exp_q.size() != 0 || m_valid); t++) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] msg9[$];
    logic [7:0] msg0[$];
    logic [7:0] rmsg[$];
    int         w;
    int         dc;
    int         frames;

    msg9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    msg0 = '{8'h00};
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    frames = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_crc_out", {16'd0, crc_out}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference frame, continuous traffic: eleven beats in eleven cycles.
    beat_cyc.delete();
    send_frame(msg9, 1'b0, w);
    frames++;
    s_valid = 1'b0;
    drain("ccitt");
    chk("ccitt_crc", {16'd0, crc_out}, 32'h29B1);
    chk("init0_crc", {16'd0, crc_out_z}, 32'h31C3);
    chk("ccitt_beats", beat_cyc.size(), 32'd11);
    if (beat_cyc.size() == 11) chk("ccitt_span", beat_cyc[10] - beat_cyc[0], 32'd10);

    send_frame(msg0, 1'b0, w);
    frames++;
    s_valid = 1'b0;
    drain("single");
    chk("single_crc", {16'd0, crc_out}, 32'hE1F0);

    // Backpressure and gapped input, then random frames.
    rdy_rand = 1'b1;
    send_frame(msg9, 1'b1, w);
    frames++;
    s_valid = 1'b0;
    drain("bp");
    chk("bp_crc", {16'd0, crc_out}, 32'h29B1);
    for (int f = 0; f < 8; f++) begin
      rmsg.delete();
      repeat ($urandom_range(1, 12)) rmsg.push_back(8'($urandom));
      send_frame(rmsg, 1'b1, w);
      frames++;
    end
    s_valid = 1'b0;
    drain("rand");
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back frames: input held off for exactly the two CRC beats.
    send_frame(msg9, 1'b0, w);
    send_frame(msg0, 1'b0, w);
    frames += 2;
    chk("b2b_holdoff", w, 32'd2);
    s_valid = 1'b0;
    drain("b2b");
    chk("b2b_crc", {16'd0, crc_out}, 32'hE1F0);
    chk("done_count", done_cnt, frames);

    // Abort mid-frame with reset.
    mon_en = 1'b0;
    dc = done_cnt;
    for (int k = 0; k < 4; k++) send_byte(msg9[k], 1'b0, 1'b0, w);
    #1;
    rst_n = 1'b0;
    s_valid = 1'b1;
    #1;
    chk("abort_m_valid", {31'd0, m_valid}, 32'd0);
    chk("abort_m_data", {24'd0, m_data}, 32'd0);
    chk("abort_m_last", {31'd0, m_last}, 32'd0);
    chk("abort_crc_out", {16'd0, crc_out}, 32'd0);
    chk("abort_crc_done", {31'd0, crc_done}, 32'd0);
    chk("abort_s_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle", {31'd0, m_valid}, 32'd0);
    chk("abort_no_done", done_cnt, dc);
    mon_en = 1'b1;
    send_frame(msg0, 1'b0, w);
    s_valid = 1'b0;
    drain("post_abort");
    chk("post_abort_crc", {16'd0, crc_out}, 32'hE1F0);
    chk("post_abort_done", done_cnt, dc + 1);
    chk("crc_q_empty", exp_crc_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc16_tx_framer.md
Name: crc16_tx_framer

Overview:
- Transmit-side framing stage that sits directly downstream of the byte-parallel CRC-16 engine in the CRC datapath.
- Accepts a payload byte stream (valid/ready plus last), forwards every byte unchanged and computes CRC-16 byte-parallel, MSB-first.
- Appends the two CRC bytes, high byte first, and marks the low CRC byte as frame end.
- Also exposes the finished CRC word with a one-cycle done strobe for status/logging.

Parameters:
- POLY, 16'h1021, generator polynomial with the implicit x^16 term omitted.
- INIT, 16'hFFFF, CRC register value at reset and at the start of every frame.
- XOROUT, 16'h0000, value XORed into the CRC before it is appended and reported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  8  payload byte.
- s_valid  input  1  s_data/s_last are valid.
- s_last  input  1  current byte is the final payload byte of the frame.
- s_ready  output  1  framer accepts the byte this cycle.
- m_data  output  8  output byte (payload or CRC).
- m_valid  output  1  m_data/m_last are valid.
- m_last  output  1  byte is the final byte of the frame (CRC low byte).
- m_ready  input  1  downstream accepts the byte this cycle.
- crc_out  output  16  final CRC (after XOROUT) of the last completed frame.
- crc_done  output  1  one-cycle pulse when the CRC low byte is loaded into the output register.

Behaviour:
- Reset (async, rst_n=0): state=PAYLOAD, crc register=INIT, m_valid=0, m_last=0, m_data=0, crc_out=0, crc_done=0, s_ready=0 while in reset. Release is synchronous to clk.
- Single output register. Define out_free = !m_valid || m_ready; the register may load only when out_free=1.
- Latency: one cycle from input handshake to m_valid. Full throughput is one byte per cycle when m_ready is held high.
- CRC update per accepted byte d, bits i=7..0:
  - fb = crc[15]^d[i]
  - crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0)
  - The update is purely combinational within the cycle, so there is no stall.
- State PAYLOAD:
  - s_ready = out_free.
  - On s_valid && s_ready: m_data <= s_data, m_last <= 0, m_valid <= 1, crc <= next.
  - If s_last is also set, go to CRC_HI.
- State CRC_HI:
  - s_ready = 0.
  - When out_free: m_data <= (crc^XOROUT)[15:8], m_last <= 0, m_valid <= 1, go to CRC_LO.
- State CRC_LO:
  - s_ready = 0.
  - When out_free: m_data <= (crc^XOROUT)[7:0], m_last <= 1, m_valid <= 1.
  - Same cycle: crc_out <= crc^XOROUT, crc_done <= 1 for exactly one cycle, crc <= INIT, go to PAYLOAD.
- When out_free=0: m_valid, m_data and m_last hold stable and the state does not advance (AXI-style: no valid drop, no data change under stall).
- If nothing new loads while m_ready=1: m_valid <= 0.
- s_last on the first byte of a frame is legal; the frame is then one payload byte plus two CRC bytes. Zero-length frames cannot be expressed.
- A new frame may start in the cycle after the CRC low byte is loaded; there are no idle bubbles beyond the two CRC beats.
- s_valid asserted while s_ready=0 (CRC states) is held off. Upstream must keep data stable, and no byte is lost.
- rst_n asserted mid-frame: everything returns immediately to reset values. The partial frame is abandoned with no CRC beats and no crc_done.
- crc_out holds its value until the next frame completes.

Test Plan:
- CCITT defaults, send ASCII "123456789" (0x31..0x39, last on 0x39), m_ready=1 → output 0x31..0x39 then 0x29, 0xB1 with m_last only on 0xB1; crc_out=0x29B1; crc_done high for 1 cycle; 11 output beats in 11 consecutive cycles.
- Single byte 0x00 with s_last=1 → output 0x00, 0xE1, 0xF0 (last); crc_out=0xE1F0.
- INIT=16'h0000, "123456789" → CRC bytes 0x31, 0xC3; crc_out=0x31C3.
- Backpressure: same "123456789" frame with m_ready toggled pseudo-randomly and s_valid gapped → identical byte sequence and CRC 0x29B1; m_data stable while m_valid && !m_ready; no duplicated or dropped beats.
- Back-to-back frames "123456789" then 0x00 with s_valid continuous → s_ready low for exactly the two CRC cycles between frames; second frame CRC=0xE1F0, proving the CRC re-initialises.
- Assert rst_n low after 4 payload bytes, then release and send 0x00 → all outputs 0 during reset, no CRC beats from the aborted frame; next frame yields 0x00, 0xE1, 0xF0.
